// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the memory stall responder.
// MEM_STALL_RANDOM_EN widens the latency counter to cover the randomised extra delay.
package mem_rsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

`ifdef MEM_STALL_RANDOM_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  // x^4 + x^3 + 1, Fibonacci form: feedback is q[3] ^ q[2]
  localparam logic [3:0] LFSR_SEED = 4'b1001;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

endpackage

// File: rtl/mem_stall_lfsr.sv
// 4-bit free-running LFSR that supplies the extra response delay.
// Only built with MEM_STALL_RANDOM_EN; the default build has no LFSR at all.
`ifdef MEM_STALL_RANDOM_EN
module mem_stall_lfsr
  import mem_rsp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [3:0] out
);

  logic [3:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (enable) begin
      q <= {q[2:0], ^(q & LFSR_TAPS)};
    end
  end

  assign out = q;

endmodule
`endif

// File: rtl/mem_stall_responder.sv
// Multi-cycle data-memory target: one request at a time, fixed (or, with
// MEM_STALL_RANDOM_EN, LFSR-jittered) latency before the response is offered.
module mem_stall_responder
  import mem_rsp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_AW  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; the
  // request side is ready only in IDLE, and rsp_valid/rsp_* hold until rsp_ready.

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_stall_responder: LATENCY=%0d outside 1..15", LATENCY);
  end

  if (ADDR_W > MEM_AW + 1) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:MEM_AW+1];
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_load;
  logic                accept, enter_resp;
  logic                cap_wr;
  logic [MEM_AW:0]     cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic                eff_wr;
  logic [MEM_AW:0]     eff_addr;
  logic [DATA_W-1:0]   eff_wdata;
  logic [MEM_AW-1:0]   eff_idx;
  logic                eff_err;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem [2**MEM_AW];

`ifdef MEM_STALL_RANDOM_EN
  logic [3:0] lfsr;
  logic       unused_lfsr_hi;

  mem_stall_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (1'b1),
    .out    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[3:2];
  assign cnt_load       = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the response is formed on the acceptance edge itself, so
  // the live request fields are used instead of the (not yet loaded) captures.
  assign eff_wr    = (state == ST_IDLE) ? req_wr             : cap_wr;
  assign eff_addr  = (state == ST_IDLE) ? req_addr[MEM_AW:0] : cap_addr;
  assign eff_wdata = (state == ST_IDLE) ? req_wdata          : cap_wdata;
  assign eff_idx   = eff_addr[MEM_AW:1];
  assign eff_err   = eff_addr[0];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt = cnt_load;
          if (cnt_load != '0) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_wr    <= req_wr;
        cap_addr  <= req_addr[MEM_AW:0];
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= eff_err;
        rdata_q <= (eff_wr || eff_err) ? '0 : mem[eff_idx];
      end else if (state == ST_RESP && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // The array is deliberately outside the reset domain: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (enter_resp && eff_wr && !eff_err) begin
      mem[eff_idx] <= eff_wdata;
    end
  end

endmodule

// File: tb/tb_mem_stall_responder.sv
// Self-checking bench for mem_stall_responder: directed vector table, reset
// corner cases, a LATENCY=1 instance and a randomised phase against a word-array model.
module tb_mem_stall_responder;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LAT = 3;
`ifdef MEM_STALL_RANDOM_EN
  localparam int LAT_SPAN = 3;
`else
  localparam int LAT_SPAN = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;

  logic          req_valid1 = 1'b0, req_wr1 = 1'b0, rsp_ready1 = 1'b1;
  logic [AW-1:0] req_addr1 = '0;
  logic [DW-1:0] req_wdata1 = '0;
  logic          req_ready1, rsp_valid1, rsp_err1, busy1;
  logic [DW-1:0] rsp_rdata1;

  mem_stall_responder #(.DATA_W(DW), .ADDR_W(AW), .MEM_AW(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  mem_stall_responder #(.DATA_W(DW), .ADDR_W(AW), .MEM_AW(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .busy(busy1)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [int];
  logic [AW-1:0] wr_addrs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_lat(input string name, input int lat, input int base);
    total_cnt++;
    if (lat >= base && lat <= base + LAT_SPAN) pass_cnt++;
    else $display("FAIL %s: latency %0d, expected %0d..%0d", name, lat, base, base + LAT_SPAN);
  endtask

  // Byte address -> word slot of a 256-word array; upper address bits wrap.
  function automatic int widx(input logic [AW-1:0] a);
    return (int'(a) / 2) % 256;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total_cnt++;
      $display("FAIL req_ready_timeout: req_ready stuck at 0, expected 1");
    end
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    // Junk on the request side while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_wr    = 1'($urandom_range(0, 1));
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic wait_rsp(output int lat, output logic [DW-1:0] rd, output logic err);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    rd  = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic finish_rsp(input int hold, input logic [DW-1:0] exp_rd, input logic chk_data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      if (chk_data) check("hold_rsp_rdata", rsp_rdata, exp_rd);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int hold,
                         input logic exp_err, input logic [DW-1:0] exp_rd, input logic chk_data);
    int            lat;
    logic [DW-1:0] got_rd, want;
    logic          got_err;
    exp_q.push_back(exp_rd);
    rsp_ready = (hold == 0);
    send_req(wr, addr, wdata);
    wait_rsp(lat, got_rd, got_err);
    check_lat({tag, "_lat"}, lat, LAT);
    check({tag, "_err"}, got_err, exp_err);
    want = exp_q.pop_front();
    if (chk_data) check({tag, "_rdata"}, got_rd, want);
    if (wr && !addr[0]) begin
      model_mem[widx(addr)] = wdata;
      wr_addrs.push_back(addr);
    end
    finish_rsp(hold, want, chk_data);
  endtask

  task automatic l1_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    int lat;
    @(negedge clk);
    req_valid1 = 1'b1;
    req_wr1    = wr;
    req_addr1  = addr;
    req_wdata1 = wdata;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid1 && lat < 20);
    check_lat({tag, "_lat"}, lat, 1);
    check({tag, "_rdata"}, rsp_rdata1, exp_rd);
    @(negedge clk);
    check({tag, "_post_valid"}, rsp_valid1, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hold;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    logic [DW-1:0] rd;
    logic          err;

    vecs[0]  = '{1'b1, 16'h00A4, 16'hBEEF, 0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h00A4, 16'h0000, 0, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 16'h0012, 16'h7777, 0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0013, 16'h0000, 0, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 16'h0012, 16'h0000, 0, 1'b0, 16'h7777};
    vecs[5]  = '{1'b1, 16'h0013, 16'h1234, 0, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 16'h0012, 16'h0000, 1, 1'b0, 16'h7777};
    vecs[7]  = '{1'b1, 16'h0202, 16'h5A5A, 0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 16'h0002, 16'h0000, 0, 1'b0, 16'h5A5A};
    vecs[9]  = '{1'b0, 16'h00A4, 16'h0000, 4, 1'b0, 16'hBEEF};
    vecs[10] = '{1'b1, 16'h00A4, 16'h0001, 0, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 16'h00A4, 16'h0000, 0, 1'b0, 16'h0001};
    vecs[12] = '{1'b0, 16'hFEA4, 16'h0000, 2, 1'b0, 16'h0001};

    // Reset values while rst_n is low
    #3;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    for (int i = 0; i < 13; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].hold, vecs[i].exp_err, vecs[i].exp_rdata, 1'b1);
    end

    // Reset in the middle of WAIT drops a pending write
    run_txn("pre_abort_wr", 1'b1, 16'h0010, 16'h1111, 0, 1'b0, 16'h0000, 1'b1);
    rsp_ready = 1'b1;
    send_req(1'b1, 16'h0010, 16'hFFFF);
    check("abort_busy", busy, 1);
    check("abort_no_rsp", rsp_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", req_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("after_abort_rd", 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'h1111, 1'b1);

    // Reset in RESP drops the response but keeps the committed write
    rsp_ready = 1'b0;
    send_req(1'b1, 16'h0020, 16'hCAFE);
    wait_rsp(lat, rd, err);
    check_lat("resp_rst_lat", lat, LAT);
    #2 rst_n = 1'b0;
    #1;
    check("resp_rst_rsp_valid", rsp_valid, 0);
    check("resp_rst_rsp_rdata", rsp_rdata, 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_mem[widx(16'h0020)] = 16'hCAFE;
    wr_addrs.push_back(16'h0020);
    run_txn("committed_rd", 1'b0, 16'h0020, 16'h0000, 0, 1'b0, 16'hCAFE, 1'b1);

    // Randomised traffic against the word-array model
    for (int n = 0; n < 100; n++) begin
      logic          wr, e_err, known;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd, e_rd;
      int            hold;
      wr = 1'($urandom_range(0, 1));
      if (wr_addrs.size() > 0 && $urandom_range(0, 1) == 1)
        addr = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
      else
        addr = 16'($urandom);
      addr[15:9] = 7'($urandom);
      addr[0]    = ($urandom_range(0, 7) == 0);
      wd         = 16'($urandom);
      hold       = $urandom_range(0, 3);
      e_err      = addr[0];
      known      = e_err || wr || model_mem.exists(widx(addr));
      e_rd       = (e_err || wr || !known) ? 16'h0000 : model_mem[widx(addr)];
      run_txn($sformatf("rnd%0d", n), wr, addr, wd, hold, e_err, e_rd, known);
    end

    // LATENCY=1 instance
    l1_txn("l1_wr", 1'b1, 16'h0004, 16'h1357, 16'h0000);
    l1_txn("l1_rd", 1'b0, 16'h0004, 16'h0000, 16'h1357);
    l1_txn("l1_misaligned", 1'b0, 16'h0005, 16'h0000, 16'h0000);
    check("l1_err", rsp_err1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
